// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 constants and frame-state encoding
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line synchroniser, frame FSM and inter-bit timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_signal,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_rdy,
  output logic [7:0] rx_byte,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   sync_clk;
  logic                   data_bit;
  logic                   fall;
  logic                   timed_out;
  logic                   frame_good;

  frame_state_t           state;
  logic [2:0]             cnt;
  logic [7:0]             shift;
  logic                   parity_bit;
  logic [TW-1:0]          timer;

  assign sync_clk   = clk_sync[SYNC_STAGES-1];
  assign data_bit   = data_sync[SYNC_STAGES-1];
  assign fall       = clk_prev & ~sync_clk;
  assign timed_out  = (state != IDLE) && !fall && (timer == TIMER_LAST);
  assign frame_good = data_bit && (^{shift, parity_bit});
  assign rx_byte    = shift;

  // Strobes are combinational so the top can register them on the very next edge.
  always_comb begin
    byte_rdy    = 1'b0;
    frame_error = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    frame_error = data_bit;
        STOP:    begin
          byte_rdy    = frame_good;
          frame_error = !frame_good;
        end
        default: ;
      endcase
    end else if (timed_out) begin
      frame_error = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_prev   <= 1'b1;
      state      <= IDLE;
      cnt        <= 3'd0;
      shift      <= 8'h00;
      parity_bit <= 1'b0;
      timer      <= '0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= sync_clk;

      if (state == IDLE || fall || timed_out) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if (timed_out) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!data_bit) begin
              state <= DATA;
              cnt   <= 3'd0;
            end
          end
          DATA: begin
            shift[cnt] <= data_bit;
            if (cnt == 3'd7) begin
              state <= PARITY;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          PARITY: begin
            parity_bit <= data_bit;
            state      <= STOP;
          end
          STOP: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 make-code decoder presenting each keypress for one clock
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] IDLE_CODE      = 8'h00,
  parameter bit         DROP_EXTENDED  = 1'b0
) (
  input  logic       clock,
  input  logic       reset_signal,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] user_input,
  output logic       key_valid,
  output logic       extended,
  output logic       frame_error
);

  logic       byte_rdy;
  logic [7:0] rx_byte;
  logic       rx_error;
  logic       brk;
  logic       ext;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clock       (clock),
    .reset_signal(reset_signal),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .byte_rdy    (byte_rdy),
    .rx_byte     (rx_byte),
    .frame_error (rx_error)
  );

  // Outputs default back to idle every clock so a key is never presented twice.
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      brk         <= 1'b0;
      ext         <= 1'b0;
      user_input  <= IDLE_CODE;
      key_valid   <= 1'b0;
      extended    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      user_input  <= IDLE_CODE;
      key_valid   <= 1'b0;
      extended    <= 1'b0;
      frame_error <= rx_error;

      if (rx_error) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (byte_rdy) begin
        if (rx_byte == PS2_BREAK) begin
          brk <= 1'b1;
        end else if (rx_byte == PS2_EXT) begin
          ext <= 1'b1;
        end else if (brk) begin
          brk <= 1'b0;
          ext <= 1'b0;
        end else begin
          ext <= 1'b0;
          if (!(ext && DROP_EXTENDED)) begin
            key_valid  <= 1'b1;
            user_input <= rx_byte;
            extended   <= ext;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int TO_CYC = 200;
  localparam int HALF   = 100;

  logic       clock = 1'b0;
  logic       reset_signal = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] user_input, user_input2;
  logic       key_valid, key_valid2;
  logic       extended, extended2;
  logic       frame_error, frame_error2;

  int tests = 0;
  int errors = 0;
  int kv_cnt = 0, kv2_cnt = 0, fe_cnt = 0;
  int idle_viol = 0, width_viol = 0, clash = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_ext = 1'b0;
  logic       prev_kv = 1'b0;
  int k0, k20, f0;

  always #5 clock = ~clock;

  ps2_key_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO_CYC), .IDLE_CODE(8'h00), .DROP_EXTENDED(1'b0)) dut (
    .clock(clock), .reset_signal(reset_signal), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .user_input(user_input), .key_valid(key_valid), .extended(extended), .frame_error(frame_error));

  ps2_key_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO_CYC), .IDLE_CODE(8'h00), .DROP_EXTENDED(1'b1)) dut_drop (
    .clock(clock), .reset_signal(reset_signal), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .user_input(user_input2), .key_valid(key_valid2), .extended(extended2), .frame_error(frame_error2));

  always @(negedge clock) begin
    if (!reset_signal) begin
      if (key_valid) begin
        kv_cnt++;
        last_code = user_input;
        last_ext  = extended;
        if (prev_kv) width_viol++;
        if (frame_error) clash++;
      end else if (user_input != 8'h00) begin
        idle_viol++;
      end
      if (frame_error) fe_cnt++;
      if (key_valid2) kv2_cnt++;
    end
    prev_kv = key_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    #(HALF);
    ps2_clk = 1'b0;
    #(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] d, input logic bad_par, input int first, input int last);
    logic [10:0] fb;
    fb = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = first; i <= last; i++) send_bit(fb[i]);
    ps2_data = 1'b1;
    #(4 * HALF);
  endtask

  task automatic snap();
    k0 = kv_cnt;
    k20 = kv2_cnt;
    f0 = fe_cnt;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("reset_user_input", user_input, 8'h00);
    check_eq("reset_key_valid", key_valid, 0);
    check_eq("reset_frame_error", frame_error, 0);
    reset_signal = 1'b0;

    snap();
    send_bits(8'h1C, 1'b0, 0, 10);
    check_eq("t1_strobes", kv_cnt - k0, 1);
    check_eq("t1_code", last_code, 8'h1C);
    check_eq("t1_ext", last_ext, 0);
    check_eq("t1_drop_inst_strobes", kv2_cnt - k20, 1);

    snap();
    send_bits(8'hF0, 1'b0, 0, 10);
    send_bits(8'h1C, 1'b0, 0, 10);
    check_eq("t2_release_no_strobe", kv_cnt - k0, 0);
    snap();
    send_bits(8'h1C, 1'b0, 0, 10);
    check_eq("t2_strobes", kv_cnt - k0, 1);
    check_eq("t2_code", last_code, 8'h1C);

    snap();
    send_bits(8'h1C, 1'b0, 0, 10);
    send_bits(8'h1C, 1'b0, 0, 10);
    check_eq("typematic_strobes", kv_cnt - k0, 2);

    snap();
    send_bits(8'hE0, 1'b0, 0, 10);
    send_bits(8'h75, 1'b0, 0, 10);
    check_eq("t3_strobes", kv_cnt - k0, 1);
    check_eq("t3_code", last_code, 8'h75);
    check_eq("t3_ext", last_ext, 1);
    check_eq("t3_dropped", kv2_cnt - k20, 0);

    snap();
    send_bits(8'h1C, 1'b1, 0, 10);
    check_eq("t4_frame_error", fe_cnt - f0, 1);
    check_eq("t4_no_strobe", kv_cnt - k0, 0);
    snap();
    send_bits(8'h1C, 1'b0, 0, 10);
    check_eq("t4_recover_strobes", kv_cnt - k0, 1);
    check_eq("t4_recover_code", last_code, 8'h1C);

    snap();
    send_bits(8'h1C, 1'b0, 0, 4);
    #(TO_CYC * 10 + 1000);
    check_eq("t5_timeout_error", fe_cnt - f0, 1);
    check_eq("t5_no_strobe", kv_cnt - k0, 0);
    snap();
    send_bits(8'h2A, 1'b0, 0, 10);
    check_eq("t5_strobes", kv_cnt - k0, 1);
    check_eq("t5_code", last_code, 8'h2A);

    snap();
    send_bits(8'h1C, 1'b0, 0, 3);
    @(negedge clock);
    reset_signal = 1'b1;
    @(negedge clock);
    check_eq("t6_rst_user_input", user_input, 8'h00);
    check_eq("t6_rst_key_valid", key_valid, 0);
    check_eq("t6_rst_extended", extended, 0);
    check_eq("t6_rst_frame_error", frame_error, 0);
    reset_signal = 1'b0;
    send_bits(8'h1C, 1'b0, 4, 10);
    #(TO_CYC * 10 + 1000);
    check_eq("t6_residue_no_strobe", kv_cnt - k0, 0);
    snap();
    send_bits(8'h1C, 1'b0, 0, 10);
    check_eq("t6_strobes", kv_cnt - k0, 1);
    check_eq("t6_code", last_code, 8'h1C);

    check_eq("idle_code_when_invalid", idle_viol, 0);
    check_eq("one_clock_strobe", width_viol, 0);
    check_eq("error_valid_exclusive", clash, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
